// File: rtl/clock_time_loader.sv
// rtl/clock_time_loader.sv - automatic button presser that loads hh:mm into the clock's time or alarm counters
module clock_time_loader #(
  parameter int NS = 60,
  parameter int NH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [6:0] tgt_hrs,
  input  logic [6:0] tgt_min,
  input  logic [6:0] cur_hrs,
  input  logic [6:0] cur_min,
  output logic       timeset,
  output logic       alarmset,
  output logic       hrsadv,
  output logic       minadv,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAXN = (NS > NH) ? NS : NH;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] NH_CNT = CW'(NH);
  localparam logic [CW-1:0] NS_CNT = CW'(NS);
  localparam logic [6:0]    NH_TGT = 7'(NH);
  localparam logic [6:0]    NS_TGT = 7'(NS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HRS_CMP,
    S_HRS_STEP,
    S_MIN_CMP,
    S_MIN_STEP,
    S_RELEASE,
    S_FINISH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            mode_q;
  logic [6:0]      tgt_hrs_q;
  logic [6:0]      tgt_min_q;
  logic [CW-1:0]   step_cnt;
  logic            err_q;

  logic            latch_req;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            err_set;
  logic            set_on;

  // state register; reset abandons any load in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic plus datapath control strobes
  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_req = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if ((tgt_hrs_q >= NH_TGT) || (tgt_min_q >= NS_TGT)) begin
          err_set   = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          cnt_clr   = 1'b1;
          state_nxt = S_HRS_CMP;
        end
      end
      S_HRS_CMP: begin
        if (cur_hrs == tgt_hrs_q) begin
          cnt_clr   = 1'b1;
          state_nxt = S_MIN_CMP;
        end else if (step_cnt == NH_CNT) begin
          // a full modulus of pulses without a match: readback is not tracking
          err_set   = 1'b1;
          state_nxt = S_RELEASE;
        end else begin
          state_nxt = S_HRS_STEP;
        end
      end
      S_HRS_STEP: begin
        cnt_inc   = 1'b1;
        state_nxt = S_HRS_CMP;
      end
      S_MIN_CMP: begin
        if (cur_min == tgt_min_q) begin
          state_nxt = S_RELEASE;
        end else if (step_cnt == NS_CNT) begin
          err_set   = 1'b1;
          state_nxt = S_RELEASE;
        end else begin
          state_nxt = S_MIN_STEP;
        end
      end
      S_MIN_STEP: begin
        cnt_inc   = 1'b1;
        state_nxt = S_MIN_CMP;
      end
      S_RELEASE: begin
        state_nxt = S_FINISH;
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // latched request, step counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= 1'b0;
      tgt_hrs_q <= 7'd0;
      tgt_min_q <= 7'd0;
      step_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (latch_req) begin
        mode_q    <= mode;
        tgt_hrs_q <= tgt_hrs;
        tgt_min_q <= tgt_min;
        err_q     <= 1'b0;
      end
      if (cnt_clr) begin
        step_cnt <= '0;
      end else if (cnt_inc) begin
        step_cnt <= step_cnt + 1'b1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Moore output decode from the registered state only
  always_comb begin
    set_on   = (state == S_HRS_CMP) || (state == S_HRS_STEP) ||
               (state == S_MIN_CMP) || (state == S_MIN_STEP);
    timeset  = set_on & ~mode_q;
    alarmset = set_on & mode_q;
    hrsadv   = (state == S_HRS_STEP);
    minadv   = (state == S_MIN_STEP);
    busy     = (state != S_IDLE);
    done     = (state == S_FINISH);
    err      = err_q;
  end

endmodule

// File: tb/tb_clock_time_loader.sv
// tb/tb_clock_time_loader.sv - directed self-checking bench for clock_time_loader
module tb_clock_time_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] tgt_hrs = 7'd0;
  logic [6:0] tgt_min = 7'd0;
  logic [6:0] cur_hrs;
  logic [6:0] cur_min;
  logic       timeset, alarmset, hrsadv, minadv, busy, done, err;

  int tests = 0;
  int fails = 0;

  // behavioural clock counters
  int  t_hrs = 0, t_min = 0, a_hrs = 0, a_min = 0;
  int  p_th = 0, p_tm = 0, p_ah = 0, p_am = 0;
  logic preset = 1'b0;
  logic stuck  = 1'b0;

  // monitor counts
  logic mon_clr = 1'b0;
  int   h_hi, h_rise, m_hi, m_rise, ts_hi, ts_rise, as_hi, viol;
  logic h_prev, m_prev, ts_prev;

  int   lat;
  logic err_done, lines_done;

  clock_time_loader #(.NS(60), .NH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .tgt_hrs(tgt_hrs), .tgt_min(tgt_min), .cur_hrs(cur_hrs), .cur_min(cur_min),
    .timeset(timeset), .alarmset(alarmset), .hrsadv(hrsadv), .minadv(minadv),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign cur_hrs = stuck ? 7'd3 : 7'(mode ? a_hrs : t_hrs);
  assign cur_min = 7'(mode ? a_min : t_min);

  // counters advance on the same tick as the loader
  always @(posedge clk) begin
    if (preset) begin
      t_hrs <= p_th; t_min <= p_tm; a_hrs <= p_ah; a_min <= p_am;
    end else begin
      if (timeset  && hrsadv) t_hrs <= (t_hrs + 1) % 24;
      if (timeset  && minadv) t_min <= (t_min + 1) % 60;
      if (alarmset && hrsadv) a_hrs <= (a_hrs + 1) % 24;
      if (alarmset && minadv) a_min <= (a_min + 1) % 60;
    end
  end

  // pulse and level statistics sampled mid-cycle
  always @(negedge clk) begin
    if (mon_clr) begin
      h_hi = 0; h_rise = 0; m_hi = 0; m_rise = 0;
      ts_hi = 0; ts_rise = 0; as_hi = 0;
      h_prev = 0; m_prev = 0; ts_prev = 0;
    end else begin
      if (hrsadv) h_hi++;
      if (hrsadv && !h_prev) h_rise++;
      if (minadv) m_hi++;
      if (minadv && !m_prev) m_rise++;
      if (timeset) ts_hi++;
      if (timeset && !ts_prev) ts_rise++;
      if (alarmset) as_hi++;
      h_prev = hrsadv; m_prev = minadv; ts_prev = timeset;
    end
    if ((hrsadv && minadv) || (timeset && alarmset) ||
        ((hrsadv || minadv) && !(timeset || alarmset)))
      viol++;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_model(input int th, input int tm, input int ah, input int am);
    p_th = th; p_tm = tm; p_ah = ah; p_am = am;
    preset = 1'b1;
    @(posedge clk);
    #1 preset = 1'b0;
    @(negedge clk);
  endtask

  // issue one start from a negedge and wait (bounded) for done
  task automatic run_load(input logic m, input int th, input int tm, input int bound);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    start = 1'b1; mode = m; tgt_hrs = 7'(th); tgt_min = 7'(tm);
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i;
        err_done = err;
        lines_done = timeset | alarmset | hrsadv | minadv;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 0, 1);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    viol = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_lines", {timeset, alarmset, hrsadv, minadv}, 0);
    rst = 1'b1;
    @(negedge clk);

    // already matching
    set_model(5, 10, 0, 0);
    run_load(1'b0, 5, 10, 50);
    check("match_lat", lat, 5);
    check("match_adv", h_rise + m_rise, 0);
    check("match_ts_hi", ts_hi, 2);
    check("match_err", err_done, 0);
    check("match_as", as_hi, 0);

    // forward load
    run_load(1'b0, 7, 12, 100);
    check("fwd_lat", lat, 13);
    check("fwd_h_rise", h_rise, 2);
    check("fwd_h_hi", h_hi, 2);
    check("fwd_m_rise", m_rise, 2);
    check("fwd_m_hi", m_hi, 2);
    check("fwd_ts_rise", ts_rise, 1);
    check("fwd_ts_hi", ts_hi, 10);
    check("fwd_hrs", t_hrs, 7);
    check("fwd_min", t_min, 12);
    check("fwd_err", err_done, 0);

    // wrap-around
    set_model(22, 58, 0, 0);
    run_load(1'b0, 1, 3, 100);
    check("wrap_lat", lat, 21);
    check("wrap_h", h_rise, 3);
    check("wrap_m", m_rise, 5);
    check("wrap_hrs", t_hrs, 1);
    check("wrap_min", t_min, 3);
    check("wrap_err", err_done, 0);

    // alarm mode
    set_model(9, 9, 0, 0);
    run_load(1'b1, 6, 30, 200);
    check("alm_lat", lat, 77);
    check("alm_h", h_rise, 6);
    check("alm_m", m_rise, 30);
    check("alm_as_hi", as_hi, 74);
    check("alm_ts_hi", ts_hi, 0);
    check("alm_ahrs", a_hrs, 6);
    check("alm_amin", a_min, 30);
    check("alm_thrs", t_hrs, 9);
    check("alm_err", err_done, 0);
    mode = 1'b0;

    // out-of-range target
    run_load(1'b0, 24, 0, 50);
    check("rng_lat", lat, 2);
    check("rng_err", err_done, 1);
    check("rng_set", ts_hi + as_hi, 0);
    check("rng_adv", h_hi + m_hi, 0);

    // stuck hours readback
    set_model(0, 0, 0, 0);
    stuck = 1'b1;
    run_load(1'b0, 4, 0, 200);
    stuck = 1'b0;
    check("stk_lat", lat, 52);
    check("stk_h", h_rise, 24);
    check("stk_h_hi", h_hi, 24);
    check("stk_err", err_done, 1);
    check("stk_lines", lines_done, 0);
    check("stk_sticky", err, 1);

    // second start while busy is ignored; accepted start clears err
    set_model(5, 10, 0, 0);
    start = 1'b1; mode = 1'b0; tgt_hrs = 7'd7; tgt_min = 7'd12;
    @(negedge clk);
    start = 1'b0;
    check("bsy_err_clr", err, 0);
    repeat (3) @(negedge clk);
    start = 1'b1; tgt_hrs = 7'd10; tgt_min = 7'd20;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin lat = i; break; end
      @(negedge clk);
    end
    check("bsy_done_seen", (lat != 0) ? 1 : 0, 1);
    check("bsy_hrs", t_hrs, 7);
    check("bsy_min", t_min, 12);
    check("bsy_err", err, 0);
    repeat (2) @(negedge clk);
    check("bsy_idle", busy, 0);

    // reset during MIN_STEP
    set_model(0, 0, 0, 0);
    start = 1'b1; tgt_hrs = 7'd0; tgt_min = 7'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      if (minadv) begin lat = i; break; end
      @(negedge clk);
    end
    check("rst_mid_seen", (lat != 0) ? 1 : 0, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_lines", {timeset, alarmset, hrsadv, minadv, done}, 0);
    rst = 1'b1;
    @(negedge clk);

    check("no_overlap", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
